// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer game: FSM state encoding and
// the stimulus LFSR constants. The reaction timer core uses the same
// state width.
package reaction_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DELAY = 3'd1;
  localparam state_t ST_LIT   = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_FAULT = 3'd4;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Button front end: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   button_raw_i     asynchronous bouncy button
//   button_clean_o   debounced level (registered)
//   press_pulse_o    one-cycle pulse, cycle after button_clean_o rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw_i,
  output logic button_clean_o,
  output logic press_pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic             clean_d;
  logic             clean_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles the synced level disagrees with the clean level.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= button_raw_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      press_q     <= clean_q & ~clean_dly_q;
    end
  end

  assign button_clean_o = clean_q;
  assign press_pulse_o  = press_q;

endmodule

// File: rtl/reaction_trigger_gen.sv
// Stimulus front end for the reaction-timer game: on a start edge waits a
// pseudo-random number of ms ticks, lights the LED, and classifies the
// round as a clean press, a false start or a timeout.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start_raw      asynchronous start request (rising edge counts)
//   button_raw     asynchronous bouncy player button
//   led_on         LED drive / reaction timer enable
//   button_clean   debounced button level
//   press_pulse    one-cycle pulse on rising edge of button_clean
//   busy           high while waiting for the LED or while it is lit
//   false_start    sticky, press before LED
//   timeout        sticky, no press while LED lit
module reaction_trigger_gen
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 10000,
  parameter int unsigned MIN_DELAY_MS    = 500,
  parameter int unsigned SPAN_BITS       = 11,
  parameter int unsigned LED_TIMEOUT_MS  = 2000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_raw,
  input  logic button_raw,
  output logic led_on,
  output logic button_clean,
  output logic press_pulse,
  output logic busy,
  output logic false_start,
  output logic timeout
);

  localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DLY_MAX   = MIN_DELAY_MS + (1 << SPAN_BITS) - 1;
  localparam int unsigned DLY_W_RAW = $clog2(DLY_MAX + 1);
  localparam int unsigned DLY_W     = (DLY_W_RAW > SPAN_BITS + 1) ? DLY_W_RAW : SPAN_BITS + 1;
  localparam int unsigned TMO_W     = (LED_TIMEOUT_MS > 0) ? $clog2(LED_TIMEOUT_MS + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t             state_q;
  state_t             state_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [PRE_W-1:0]   pre_q;
  logic [PRE_W-1:0]   pre_d;
  logic [DLY_W-1:0]   dly_q;
  logic [DLY_W-1:0]   dly_d;
  logic [TMO_W-1:0]   tmo_q;
  logic [TMO_W-1:0]   tmo_d;
  logic               start_s1_q;
  logic               start_s2_q;
  logic               start_prev_q;
  logic               led_q;
  logic               led_d;
  logic               busy_q;
  logic               busy_d;
  logic               false_start_q;
  logic               false_start_d;
  logic               timeout_q;
  logic               timeout_d;
  logic               pre_clr;
  logic               start_edge;
  logic               tick;
  logic               press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_raw_i  (button_raw),
    .button_clean_o(button_clean),
    .press_pulse_o (press)
  );

  assign start_edge = start_s2_q & ~start_prev_q;
  assign tick       = (pre_q == PRE_LAST);

  // Next state; a press always wins over a same-cycle expiry.
  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    tmo_d         = tmo_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    pre_clr       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_edge) begin
          state_d       = ST_DELAY;
          dly_d         = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[SPAN_BITS-1:0]);
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
          pre_clr       = 1'b1;
        end
      end
      ST_DELAY: begin
        if (press) begin
          state_d       = ST_FAULT;
          false_start_d = 1'b1;
        end else if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            state_d = ST_LIT;
            dly_d   = '0;
            tmo_d   = TMO_W'(LED_TIMEOUT_MS);
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      ST_LIT: begin
        if (press) begin
          state_d = ST_DONE;
        end else if (tick) begin
          if (tmo_q <= TMO_W'(1)) begin
            state_d   = ST_DONE;
            tmo_d     = '0;
            timeout_d = 1'b1;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running ms prescaler, realigned on every accepted start.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (pre_clr || tick) begin
      pre_d = '0;
    end
  end

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    led_d  = (state_d == ST_LIT);
    busy_d = (state_d == ST_DELAY) || (state_d == ST_LIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      pre_q         <= '0;
      dly_q         <= '0;
      tmo_q         <= '0;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_step(lfsr_q);
      pre_q         <= pre_d;
      dly_q         <= dly_d;
      tmo_q         <= tmo_d;
      start_s1_q    <= start_raw;
      start_s2_q    <= start_s1_q;
      start_prev_q  <= start_s2_q;
      led_q         <= led_d;
      busy_q        <= busy_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
    end
  end

  assign led_on      = led_q;
  assign busy        = busy_q;
  assign false_start = false_start_q;
  assign timeout     = timeout_q;
  assign press_pulse = press;

endmodule
